// File: rtl/fifo_umbral.sv
`default_nettype none
// fifo_umbral: circular FIFO with programmable almost-full/almost-empty thresholds,
// registered one-cycle read path and a sticky overflow/underflow error flag.
module fifo_umbral #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic push_ok;
  logic pop_ok;
  logic overflow;
  logic underflow;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_CNT);
  // count never exceeds DEPTH, so a threshold above DEPTH can never be reached
  assign almost_full  = (count >= umbral_alto);
  assign almost_empty = (count <= umbral_bajo);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it
  assign pop_ok    = pop && !fifo_empty;
  assign push_ok   = push && (!fifo_full || pop_ok);
  assign overflow  = push && fifo_full && !pop_ok;
  assign underflow = pop && fifo_empty && !push;

  always_ff @(posedge clk) begin
    if (reset_L && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (overflow || underflow) begin
        error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, word width (2-bit dest + 8-bit payload).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, pointer width; depth = 2**ADDR_WIDTH (8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  write request, one arbiter Push bit.
REQ-006 SHALL have port pop  input  1  read request from the consumer stage.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  word written on accepted push.
REQ-008 SHALL have port umbral_alto  input  ADDR_WIDTH+1  almost-full threshold.
REQ-009 SHALL have port umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port valid_out  output  1  data_out holds a word popped the previous cycle.
REQ-012 SHALL have port fifo_empty  output  1  occupancy == 0.
REQ-013 SHALL have port fifo_full  output  1  occupancy == depth.
REQ-014 SHALL have port almost_full  output  1  occupancy >= umbral_alto; drives the arbiter's Almost_full bit.
REQ-015 SHALL have port almost_empty  output  1  occupancy <= umbral_bajo.
REQ-016 SHALL have port error  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL store words in a depth-entry circular memory indexed by write and read pointers of ADDR_WIDTH bits and a (ADDR_WIDTH+1)-bit occupancy counter.
REQ-018 SHALL accept a push when push=1 and (fifo_full=0 or pop=1 is accepted in the same cycle), writing data_in at wr_ptr and incrementing wr_ptr.
REQ-019 SHALL accept a pop when pop=1 and fifo_empty=0, loading mem[rd_ptr] into data_out and incrementing rd_ptr; valid_out=1 the next cycle, one-cycle read latency.
REQ-020 SHALL set valid_out=0 and hold data_out on any cycle with no accepted pop.
REQ-021 SHALL wrap both pointers from depth-1 to 0 modulo 2**ADDR_WIDTH.
REQ-022 SHALL update occupancy: +1 push only, -1 pop only, unchanged when both or neither are accepted.
REQ-023 SHALL, on simultaneous push and pop while full, accept both; occupancy stays at depth and the popped word is the oldest entry.
REQ-024 SHALL, on simultaneous push and pop while empty, accept only the push; the pop is ignored and NOT flagged as an error.
REQ-025 SHALL ignore a push while full without an accepted pop (memory and pointers unchanged) and set error=1.
REQ-026 SHALL ignore a pop while empty without a push and set error=1.
REQ-027 SHALL hold error=1 until reset.
REQ-028 SHALL derive fifo_empty, fifo_full, almost_full and almost_empty combinationally from the registered occupancy and current thresholds, with no added latency.
REQ-029 SHALL treat umbral_alto=0 as always almost_full, and umbral_alto>depth as never almost_full.

Reset
REQ-030 SHALL, while reset_L=0, asynchronously clear wr_ptr, rd_ptr, occupancy, data_out, valid_out and error to 0, regardless of clk.
REQ-031 SHALL therefore present fifo_empty=1, fifo_full=0 and almost_empty=1 during and after reset, with almost_full=1 only if umbral_alto=0.
REQ-032 SHALL leave memory contents undefined after reset; no read returns them before they are rewritten.
REQ-033 SHALL discard in-flight operations when reset asserts mid-transfer, and accept the first push on the first rising edge after reset_L returns to 1.

Verification
REQ-034 SHALL be covered by: umbral_alto=6, 8 pushes of 0x000..0x007 -> almost_full rises after the 6th push, fifo_full after the 8th, error=0.
REQ-035 SHALL be covered by: full FIFO, then 8 pops -> data_out=0x000..0x007 in order, each one cycle after its pop; fifo_empty=1 after the 8th.
REQ-036 SHALL be covered by: full FIFO, push 0x3FF with pop in one cycle -> occupancy stays 8, data_out=oldest word, 0x3FF read out last, error=0.
REQ-037 SHALL be covered by: empty FIFO, pop=1 alone -> error=1, valid_out=0; error persists until reset_L=0.
REQ-038 SHALL be covered by: 12 push/pop pairs interleaved across pointer wrap -> data order preserved, occupancy correct.
REQ-039 SHALL be covered by: reset_L pulsed low between clock edges with 5 words stored -> outputs clear immediately, fifo_empty=1, next push lands at address 0.
